// File: rtl/ex_muldiv_seq_if.sv
// EX <-> multiply/divide sequencer bundle: request, response and stall signals.
// No timing of its own; pure grouping of the handshake wires.
// master = EX stage side, slave = sequencer side.
interface ex_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;
    logic            busy;

    modport master (
        output req_valid, funct3, op_a, op_b, rd_in, flush, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_rd, busy
    );

    modport slave (
        input  req_valid, funct3, op_a, op_b, rd_in, flush, resp_ready,
        output req_ready, resp_valid, resp_result, resp_rd, busy
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply / restoring divide on magnitudes.
// Latency: result valid 34 cycles after accept; divide-by-zero and signed overflow valid after 1.
// Backpressure: one op at a time (req_ready only when idle); result held while resp_ready is low.
module ex_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    ex_muldiv_seq_if.slave     io
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state, state_next;
    logic [2*XLEN-1:0] acc;        // mul: product/multiplier; div: remainder(hi)/quotient(lo)
    logic [XLEN-1:0]   opnd;       // mul: multiplicand; div: divisor
    logic [2:0]        op_q;
    logic              neg_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   res_q;
    logic [CNT_W-1:0]  cnt;

    // Request decode: signedness, magnitudes, special-case detection
    logic              accept;
    logic              is_div;
    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic              neg_in;
    logic [XLEN-1:0]   special_res;

    assign accept = io.req_valid && (state == S_IDLE) && !io.flush;
    assign is_div = io.funct3[2];

    // Operand signedness and magnitudes, plus the divide shortcuts that bypass iteration
    always_comb begin
        sa          = 1'b0;
        sb          = 1'b0;
        special_res = '0;
        case (io.funct3)
            3'b001:  begin sa = io.op_a[XLEN-1]; sb = io.op_b[XLEN-1]; end
            3'b010:  begin sa = io.op_a[XLEN-1]; end
            3'b100,
            3'b110:  begin sa = io.op_a[XLEN-1]; sb = io.op_b[XLEN-1]; end
            default: begin sa = 1'b0; sb = 1'b0; end
        endcase
        mag_a    = sa ? (~io.op_a + 1'b1) : io.op_a;
        mag_b    = sb ? (~io.op_b + 1'b1) : io.op_b;
        // REM keeps the dividend's sign; everything else takes the product sign
        neg_in   = (is_div && io.funct3[1]) ? sa : (sa ^ sb);
        div_zero = is_div && (io.op_b == '0);
        div_ovf  = is_div && !io.funct3[0] && (io.op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (io.op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = io.funct3[1] ? io.op_a : '1;
        else if (div_ovf)
            special_res = io.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration of either algorithm
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    // Shift-add multiply step and restoring divide step on the shared accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        // acc[2X-1:X-1] is the remainder already shifted left with the next dividend bit in
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    // Negate the finished magnitude when required, then pick the word the op returns
    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        fix_res  = '0;
        case (op_q)
            3'b000:         fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: fix_res = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
            default:        fix_res = neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; flush kills any in-flight or pending-response operation
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == CNT_W'(XLEN-1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (io.resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (io.flush && state != S_IDLE)
            state_next = S_IDLE;
    end

    // Datapath: latch operands on accept, iterate in CALC, capture result in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            rd_q  <= '0;
            res_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            op_q  <= io.funct3;
            neg_q <= neg_in;
            rd_q  <= io.rd_in;
            cnt   <= '0;
            acc   <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd  <= is_div ? mag_b : mag_a;
            if (special)
                res_q <= special_res;
        end else if (state == S_CALC) begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
        end else if (state == S_FIX) begin
            res_q <= fix_res;
        end
    end

    assign io.req_ready   = (state == S_IDLE);
    assign io.resp_valid  = (state == S_DONE);
    assign io.busy        = (state != S_IDLE);
    assign io.resp_result = res_q;
    assign io.resp_rd     = rd_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed vector table, multi-cycle corner sequences, random ops vs model.
// Cycle 0 = accept cycle; latency counts rising edges from the accept edge to resp_valid.
// Outputs sampled 1 time unit after the rising edge, inputs driven on the falling edge.
module tb_ex_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_seq_if #(.XLEN(32)) io ();

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model straight from RV32M arithmetic rules
    function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Wait until idle, present one request, return just after the accept edge
    task automatic start_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (!io.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " req_ready"}, 32'(io.req_ready), 32'd1);
        io.req_valid = 1'b1;
        io.funct3    = f3;
        io.op_a      = a;
        io.op_b      = b;
        io.rd_in     = rd;
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
        io.op_a      = $urandom;
        io.op_b      = $urandom;
    endtask

    // Count edges to resp_valid, checking busy throughout and the delivered result
    task automatic wait_resp(input string nm, input logic [31:0] exp, input logic [4:0] exp_rd,
                             input int exp_lat);
        int lat = 1;
        bit busy_ok = 1'b1;
        while (!io.resp_valid && lat < 100) begin
            if (!io.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " resp_valid"}, 32'(io.resp_valid), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, io.resp_result, exp);
        chk({nm, " rd"}, 32'(io.resp_rd), 32'(exp_rd));
        chk({nm, " busy"}, 32'(busy_ok && io.busy), 32'd1);
        chk({nm, " req_ready in DONE"}, 32'(io.req_ready), 32'd0);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        start_op(nm, f3, a, b, rd);
        wait_resp(nm, exp, rd, exp_lat);
        @(posedge clk);
        #1;
        chk({nm, " drained"}, 32'(io.resp_valid), 32'd0);
        chk({nm, " idle"}, 32'(io.req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        34};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h0,        1};
        vecs[12] = '{3'd0, 32'd3,          32'd4,        32'd12,       34};
        vecs[13] = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{3'd6, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 1};
        vecs[15] = '{3'd4, 32'h80000000,   32'd1,        32'h80000000, 34};

        rst           = 1'b1;
        io.req_valid  = 1'b0;
        io.funct3     = 3'd0;
        io.op_a       = '0;
        io.op_b       = '0;
        io.rd_in      = '0;
        io.flush      = 1'b0;
        io.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", 32'(io.resp_valid), 32'd0);
        chk("reset resp_result", io.resp_result, 32'd0);
        chk("reset resp_rd", 32'(io.resp_rd), 32'd0);
        chk("reset busy", 32'(io.busy), 32'd0);
        chk("reset req_ready", 32'(io.req_ready), 32'd1);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat);

        // Flush during CALC at cycle 10, then MUL 3x4 accepted at cycle 11
        start_op("flush calc", 3'd0, 32'd5, 32'd6, 5'd3);
        seen = 1'b0;
        repeat (9) begin
            if (io.resp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.flush = 1'b0;
        chk("flush calc busy", 32'(io.busy), 32'd0);
        chk("flush calc req_ready", 32'(io.req_ready), 32'd1);
        chk("flush calc no resp", 32'(seen || io.resp_valid), 32'd0);
        run_op("after flush mul", 3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 34);

        // Response held under backpressure
        io.resp_ready = 1'b0;
        start_op("hold", 3'd5, 32'd100, 32'd7, 5'd9);
        wait_resp("hold", 32'd14, 5'd9, 34);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid", k), 32'(io.resp_valid), 32'd1);
            chk($sformatf("hold%0d result", k), io.resp_result, 32'd14);
            chk($sformatf("hold%0d rd", k), 32'(io.resp_rd), 32'd9);
        end
        @(negedge clk);
        io.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold release valid", 32'(io.resp_valid), 32'd0);
        chk("hold release req_ready", 32'(io.req_ready), 32'd1);

        // Flush wins over resp_ready in DONE
        io.resp_ready = 1'b0;
        start_op("flush done", 3'd3, 32'd11, 32'd13, 5'd4);
        wait_resp("flush done", 32'd0, 5'd4, 34);
        @(negedge clk);
        io.flush      = 1'b1;
        io.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        io.flush = 1'b0;
        chk("flush done valid", 32'(io.resp_valid), 32'd0);
        chk("flush done busy", 32'(io.busy), 32'd0);

        // Flush in IDLE blocks the same-cycle request
        @(negedge clk);
        io.flush     = 1'b1;
        io.req_valid = 1'b1;
        io.funct3    = 3'd0;
        io.op_a      = 32'd2;
        io.op_b      = 32'd2;
        @(posedge clk);
        #1;
        chk("flush idle busy", 32'(io.busy), 32'd0);
        @(negedge clk);
        io.flush     = 1'b0;
        io.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush idle still idle", 32'(io.busy), 32'd0);

        // Reset mid-operation
        start_op("rst mid", 3'd4, 32'd1000, 32'd3, 5'd21);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid busy", 32'(io.busy), 32'd0);
        chk("rst mid valid", 32'(io.resp_valid), 32'd0);
        chk("rst mid result", io.resp_result, 32'd0);
        chk("rst mid rd", 32'(io.resp_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random operations against the model, with edge operands mixed in
        for (int i = 0; i < 50; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'hFFFFFFFF;
                default: ;
            endcase
            rd = 5'($urandom);
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, rd, ref_calc(f3, a, b),
                   ref_lat(f3, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer attached to the EX stage, replacing the single-cycle combinational product path. It accepts one operation at a time from EX and runs a 32-step shift-add multiply or restoring divide on operand magnitudes. It returns a sign-fixed 32-bit result under a valid/ready handshake and stalls upstream stages while busy. A branch/flush input kills an in-flight operation.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, 6, iteration counter width (ceil(log2(XLEN))+1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  EX presents an M-extension instruction
req_ready  out  1  sequencer idle, can accept
funct3  in  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  32  rs1 value
op_b  in  32  rs2 value
rd_in  in  5  destination register
flush  in  1  kill current/incoming operation (taken branch or jump)
resp_valid  out  1  result available
resp_ready  in  1  downstream accepts result; low during memory-access stall
resp_result  out  32  final result
resp_rd  out  5  destination register of result
busy  out  1  state != IDLE; used as EX stall

Behaviour:
- Reset: state IDLE; resp_valid 0, resp_result 0, resp_rd 0, counter 0, internal accumulators 0.
- req_ready = (state == IDLE). accept = req_valid & req_ready & ~flush.
- Signedness: MULH ss, MULHSU a signed/b unsigned, MULHU uu, MUL uu; DIV/REM signed; DIVU/REMU unsigned. On accept, latch |a|, |b|, neg_res, funct3, rd_in.
- neg_res: multiply = sa^sb; DIV = sa^sb; REM = sa.
- States: IDLE -> CALC on accept (counter = 0). CALC -> FIX after 32 iterations (counter == 31 in that cycle). FIX -> DONE. DONE -> IDLE when resp_ready. Any non-IDLE state -> IDLE on flush, with no response issued.
- Latency: accept at cycle 0; CALC cycles 1..32; FIX cycle 33; resp_valid = 1 from cycle 34.
- Multiply step: 64-bit product register; add the multiplicand when the multiplier LSB is 1, then shift right one bit.
- Divide step: restoring divide; shift remainder/quotient left, subtract divisor, keep the result if non-negative and set the quotient bit.
- FIX: two's-complement negate the 64-bit product or the quotient/remainder when neg_res is set, then select the result:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases skip CALC and FIX and reach DONE at cycle 1:
  - Divide by zero (op_b == 0): quotient 0xFFFFFFFF, remainder op_a.
  - Signed overflow (DIV/REM with op_a 0x80000000, op_b 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE: resp_result and resp_rd stay stable while resp_valid is high and resp_ready is low. The result is dropped only on resp_ready or flush.
- flush in IDLE blocks the same-cycle request. flush takes priority over resp_ready in DONE; resp_valid is 0 the next cycle.
- No new request is accepted in the cycle DONE -> IDLE; the earliest next accept is the following cycle.
- rst mid-operation: return to IDLE next cycle, all outputs at their reset values.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, accept cycle 0 -> resp_valid at cycle 34, resp_result 0xFFFFFFEB; busy high cycles 1..34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF at cycle 1. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0.
- flush at cycle 10 during CALC -> IDLE and req_ready=1 at cycle 11, resp_valid never asserted. A new MUL 3x4 accepted at cycle 11 -> result 12 at cycle 45.
- resp_ready held low 3 cycles in DONE -> resp_result/resp_rd stable. resp_ready high -> IDLE next cycle. flush plus resp_valid in DONE -> result dropped.
